rr_rv_arbiter: RTL
==================

// Module: rr_rv_arbiter
// PURPOSE
//  Round-robin arbiter sharing one ready/valid request/response channel between NUM_REQ requesters.
//  Responses return in order; a tag FIFO of granted indices routes each one to its requester.
//  Outstanding transactions are capped at MAX_OUTST. Sits in front of a shared memory/bus port
//  where fixed priority would starve low-priority masters.
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..16
//  DATA_W     16  request/response payload width
//  MAX_OUTST  8   max accepted-but-unanswered requests; also the tag FIFO depth, 1..16
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid      in   NUM_REQ         per-requester request valid
//  req_ready      out  NUM_REQ         per-requester request ready
//  req_data       in   NUM_REQ*DATA_W  request payloads; requester i at [i*DATA_W +: DATA_W]
//  rsp_valid      out  NUM_REQ         per-requester response valid
//  rsp_ready      in   NUM_REQ         per-requester response ready
//  rsp_data       out  DATA_W          response payload, broadcast to all requesters
//  out_req_valid  out  1               downstream request valid
//  out_req_ready  in   1               downstream request ready
//  out_req_data   out  DATA_W          selected request payload
//  out_rsp_valid  in   1               downstream response valid
//  out_rsp_ready  out  1               downstream response ready
//  out_rsp_data   in   DATA_W          downstream response payload
//  grant          out  $clog2(NUM_REQ) index currently presented downstream
//  outstanding    out  $clog2(MAX_OUTST+1) count of in-flight requests
//  err_orphan     out  1               sticky: out_rsp_valid seen while no request outstanding
// BEHAVIOUR
//  Reset (rst=0, async): last_grant = NUM_REQ-1, so requester 0 has top priority.
//   Also clears hold, outstanding=0, tag FIFO empty, err_orphan=0.
//   All valid/ready outputs drive 0 during reset. grant is 0 out of reset with no requests.
//  Arbitration (comb): scan from last_grant+1, wrapping, for the first set req_valid bit.
//   With no request, grant = last_grant+1 mod NUM_REQ.
//  can_issue = (outstanding < MAX_OUTST) & ~fifo_full.
//  out_req_valid = req_valid[grant] & can_issue; out_req_data = req_data[grant].
//  req_ready[i] = (i==grant) & out_req_ready & can_issue; all other bits are 0.
//  accept = out_req_valid & out_req_ready. On accept:
//   - push grant into the tag FIFO, last_grant <= grant, outstanding +1.
//  Hold: if out_req_valid & ~out_req_ready, register hold=1 and freeze grant until accept.
//   A higher-priority arrival must not change grant mid-handshake (valid stays stable).
//  Response routing: head = FIFO head tag.
//   rsp_valid[head] = out_rsp_valid & ~fifo_empty; out_rsp_ready = rsp_ready[head] & ~fifo_empty.
//   rsp_data = out_rsp_data, zero-latency pass-through.
//   rsp_done = out_rsp_valid & out_rsp_ready pops the FIFO and decrements outstanding.
//  Same-cycle accept and rsp_done: outstanding unchanged; FIFO pushes and pops.
//   Push is gated by full/outstanding as sampled at cycle start; no same-cycle bypass when full.
//  out_rsp_valid with FIFO empty: out_rsp_ready=0 (response stalls), err_orphan <= 1 until reset.
//  Latency: request path combinational, 0 cycles. Arbitration pointer updates on the next edge.
//  Wrap-around: last_grant = NUM_REQ-1 scans from 0. Pointer arithmetic is mod NUM_REQ,
//   not mod 2^width.
//  Reset mid-operation: all in-flight tags are discarded; later responses raise err_orphan.
// CONFIGURATION
//  `ARB_LOCK_EN defined:
//   - adds input req_lock [NUM_REQ].
//   - accepting a beat with req_lock[grant]=1 sets lock; the following arbitrations return that
//     same requester, even if it is idle, until a beat with lock=0 is accepted.
//   - reset clears lock.
//  `ARB_LOCK_EN undefined: the req_lock port and lock logic are absent; pure round-robin.
// STRUCTURE
//  Package arb_pkg:
//   - localparams for the index width and count width.
//   - function rr_pick(valid, last) used for the round-robin scan.
//   - typedef grant_t.
//  Sub-module rr_tag_fifo: synchronous FIFO, depth MAX_OUTST, width $clog2(NUM_REQ).
//   - outputs full/empty and a registered head; flop-based, async active-low reset.
// TESTING
//  1. All 4 valid, out ready and responses immediate -> grants 0,1,2,3,0 on consecutive cycles;
//     each rsp_valid pulses one cycle after its requester's accept.
//  2. req 2 valid, out_req_ready=0 for 3 cycles, req 0 raised at cycle 1 -> grant holds at 2;
//     req 2 accepted at cycle 3, then grant=0.
//  3. MAX_OUTST=8, no responses, req 1 valid -> 8 accepts, then req_ready=0 and outstanding=8;
//     one response -> outstanding=7 and the next accept is allowed.
//  4. Accepts 3,0,2 -> responses routed to rsp_valid[3], [0], [2] in order.
//     rsp_ready[0]=0 stalls out_rsp_ready.
//  5. out_rsp_valid=1 with nothing outstanding -> out_rsp_ready=0, err_orphan=1, sticky;
//     cleared only by rst=0.
//  6. (`ARB_LOCK_EN) req 1 accepts lock=1,1,0 while req 0 and req 2 are valid
//     -> three consecutive grants to 1, then grant=2.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, default sizing and the round-robin scan used by rr_rv_arbiter.
package arb_pkg;

  localparam int unsigned ARB_NUM_REQ   = 4;
  localparam int unsigned ARB_DATA_W    = 16;
  localparam int unsigned ARB_MAX_OUTST = 8;
  localparam int unsigned ARB_MAX_REQ   = 16;
  localparam int unsigned GRANT_W       = 4;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned arb_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned ARB_IDX_W = arb_idx_w(ARB_NUM_REQ);
  localparam int unsigned ARB_CNT_W = arb_cnt_w(ARB_MAX_OUTST);

  typedef logic [GRANT_W-1:0] grant_t;

  // Offsets are visited from farthest (last itself) to nearest (last+1) so the
  // nearest set bit overwrites and wins; with nothing valid the answer is last+1.
  function automatic grant_t rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                     input grant_t last, input int unsigned n);
    grant_t pick;
    grant_t idx;
    pick = grant_t'((32'(last) + 32'd1) % n);
    for (int unsigned k = 0; k < n; k++) begin
      idx = grant_t'((32'(last) + n - k) % n);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_tag_fifo.sv
// Flop-based tag FIFO holding granted requester indices; head is registered.
module rr_tag_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARB_MAX_OUTST,
  parameter int unsigned WIDTH = ARB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = arb_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_next = ptr_inc(rd_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Head tracks the entry at the post-update read pointer; a push into an
      // empty (or draining-to-empty) FIFO has to bypass the storage array.
      if (do_push && (empty || (do_pop && count == CNT_W'(1))))
        head <= push_data;
      else if (do_pop && count > CNT_W'(1))
        head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/rr_rv_arbiter.sv
// Round-robin ready/valid arbiter with in-order response routing via a tag FIFO.
// Optional grant locking is compiled in with `ARB_LOCK_EN.
module rr_rv_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = ARB_NUM_REQ,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned MAX_OUTST = ARB_MAX_OUTST,
  localparam int unsigned IDX_W    = arb_idx_w(NUM_REQ),
  localparam int unsigned CNT_W    = arb_cnt_w(MAX_OUTST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      out_req_valid,
  input  logic                      out_req_ready,
  output logic [DATA_W-1:0]         out_req_data,
  input  logic                      out_rsp_valid,
  output logic                      out_rsp_ready,
  input  logic [DATA_W-1:0]         out_rsp_data,
  output logic [IDX_W-1:0]          grant,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_orphan
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] hold_grant;
  logic [IDX_W-1:0] grant_c;
  logic [IDX_W-1:0] head;
  logic             hold;
  logic [CNT_W-1:0] out_cnt;
  logic             orphan_q;
  logic             can_issue;
  logic             sel_valid;
  logic             head_ready;
  logic             accept;
  logic             rsp_done;
  logic             fifo_full;
  logic             fifo_empty;
`ifdef ARB_LOCK_EN
  logic             lock;
  logic [IDX_W-1:0] lock_grant;
`endif

  always_comb begin
    grant_c = IDX_W'(rr_pick(ARB_MAX_REQ'(req_valid), grant_t'(last_grant), NUM_REQ));
`ifdef ARB_LOCK_EN
    if (lock) grant_c = lock_grant;
`endif
    if (hold) grant_c = hold_grant;
  end

  // rst gates the request side so nothing handshakes while reset is asserted.
  assign can_issue = (out_cnt < CNT_W'(MAX_OUTST)) & ~fifo_full & rst;

  always_comb begin
    sel_valid    = 1'b0;
    head_ready   = 1'b0;
    out_req_data = '0;
    req_ready    = '0;
    rsp_valid    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_c) begin
        sel_valid    = req_valid[i];
        out_req_data = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = out_req_ready & can_issue;
      end
      if (IDX_W'(i) == head) begin
        head_ready   = rsp_ready[i];
        rsp_valid[i] = out_rsp_valid & ~fifo_empty;
      end
    end
  end

  assign out_req_valid = sel_valid & can_issue;
  assign accept        = out_req_valid & out_req_ready;
  assign out_rsp_ready = head_ready & ~fifo_empty;
  assign rsp_done      = out_rsp_valid & out_rsp_ready;
  assign rsp_data      = out_rsp_data;
  assign grant         = grant_c;
  assign outstanding   = out_cnt;
  assign err_orphan    = orphan_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      hold       <= 1'b0;
      hold_grant <= '0;
      out_cnt    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      hold       <= out_req_valid & ~out_req_ready;
      hold_grant <= grant_c;
      if (accept) last_grant <= grant_c;
      if (accept && !rsp_done)
        out_cnt <= out_cnt + CNT_W'(1);
      else if (!accept && rsp_done)
        out_cnt <= out_cnt - CNT_W'(1);
      if (out_rsp_valid && fifo_empty) orphan_q <= 1'b1;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock       <= 1'b0;
      lock_grant <= '0;
    end else if (accept) begin
      lock       <= req_lock[grant_c];
      lock_grant <= grant_c;
    end
  end
`endif

  rr_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (grant_c),
    .pop       (rsp_done),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
